// File: rtl/spi_responder.sv
// SPI responder: synchronizes SCLK/CS_n/MOSI into aclk and moves DATA_WIDTH-bit words in all CPOL/CPHA modes.
// Optional macro SPI_RESPONDER_LSB_FIRST_EN switches both RX and TX to LSB-first bit order.
`timescale 1ns/1ps
module spi_responder #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic                   mode_cpol;
  logic                   mode_cpha;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  rx_shift;
  logic [DATA_WIDTH-1:0]  tx_shift;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   lead_edge;
  logic                   trail_edge;
  logic                   sample_edge;
  logic                   shift_edge;
  logic [DATA_WIDTH-1:0]  tx_word;
  logic [DATA_WIDTH-1:0]  rx_next;
  logic [DATA_WIDTH-1:0]  tx_rest;
  logic [DATA_WIDTH-1:0]  word_rest;
  logic                   tx_head;
  logic                   word_head;

  // CS synchronizer resets to the inactive level so reset release never looks like a CS fall.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  assign lead_edge   = mode_cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_cpol ? sclk_rise : sclk_fall;
  assign sample_edge = mode_cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode_cpha ? lead_edge : trail_edge;

  assign tx_word = tx_valid ? tx_data : '0;

`ifdef SPI_RESPONDER_LSB_FIRST_EN
  assign rx_next   = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
  assign tx_head   = tx_shift[0];
  assign tx_rest   = {1'b0, tx_shift[DATA_WIDTH-1:1]};
  assign word_head = tx_word[0];
  assign word_rest = {1'b0, tx_word[DATA_WIDTH-1:1]};
`else
  assign rx_next   = {rx_shift[DATA_WIDTH-2:0], mosi_s};
  assign tx_head   = tx_shift[DATA_WIDTH-1];
  assign tx_rest   = {tx_shift[DATA_WIDTH-2:0], 1'b0};
  assign word_head = tx_word[DATA_WIDTH-1];
  assign word_rest = {tx_word[DATA_WIDTH-2:0], 1'b0};
`endif

  // Transaction FSM; CS events take priority over any SCLK edge seen in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      mode_cpol   <= 1'b0;
      mode_cpha   <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      tx_ready    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            mode_cpol   <= cpol;
            mode_cpha   <= cpha;
            bit_cnt     <= '0;
            busy        <= 1'b1;
            spi_miso_oe <= 1'b1;
            tx_ready    <= tx_valid;
            // cpha=0 presents the first bit immediately; cpha=1 waits for the first leading edge.
            if (cpha) begin
              spi_miso <= 1'b0;
              tx_shift <= tx_word;
            end else begin
              spi_miso <= word_head;
              tx_shift <= word_rest;
            end
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            busy        <= 1'b0;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
            bit_cnt     <= '0;
          end else begin
            if (sample_edge) begin
              rx_shift <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt  <= '0;
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ready) begin
                  overrun <= 1'b1;
                end
                tx_shift <= tx_word;
                tx_ready <= tx_valid;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            if (shift_edge) begin
              spi_miso <= tx_head;
              tx_shift <= tx_rest;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: behavioural SPI controller, word-level reference model, table plus random transfers.
`timescale 1ns/1ps
module tb_spi_responder;

  localparam int unsigned W    = 24;
  localparam int unsigned SYNC = 2;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         cpol;
  logic         cpha;
  logic         spi_sclk;
  logic         spi_cs_n;
  logic         spi_mosi;
  logic         spi_miso;
  logic         spi_miso_oe;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         overrun;
  logic         busy;

  spi_responder #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .aclk(aclk), .aresetn(aresetn), .cpol(cpol), .cpha(cpha),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  logic [W-1:0] send_q[$];
  logic [W-1:0] got_q[$];
  int tx_base = 0;
  int tx_lim  = 0;
  int tx_rd   = 0;
  int tx_pulses = 0;

  typedef struct {
    logic         cp;
    logic         ch;
    logic [W-1:0] mosi;
    logic [W-1:0] tx;
    logic         txv;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_miso;
    int           exp_rdy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bit_idx(input int i);
`ifdef SPI_RESPONDER_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  // TX word source and RX sink, both evaluated away from the active edge.
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge aclk);
      if (rx_valid && rx_ready) rxq.push_back(rx_data);
      if (tx_rd < tx_base) tx_rd = tx_base;
      if (tx_ready) begin
        tx_pulses++;
        if (tx_rd < tx_lim) tx_rd++;
      end
      tx_valid = (tx_rd < tx_lim);
      tx_data  = (tx_rd < tx_lim) ? txq[tx_rd] : '0;
    end
  end

  task automatic flush_tx();
    tx_base = txq.size();
    tx_lim  = txq.size();
  endtask

  task automatic spi_begin(input logic cp, input logic ch);
    @(negedge aclk);
    cpol = cp;
    cpha = ch;
    spi_sclk = cp;
    spi_mosi = 1'b0;
    #100 spi_cs_n = 1'b0;
    #100;
  endtask

  task automatic spi_word(input logic [W-1:0] w, input int nbits, output logic [W-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx = bit_idx(i);
      if (!cpha) begin
        spi_mosi = w[idx];
        #40 got[idx] = spi_miso;
        spi_sclk = ~cpol;
        #40 spi_sclk = cpol;
      end else begin
        spi_sclk = ~cpol;
        spi_mosi = w[idx];
        #40 got[idx] = spi_miso;
        spi_sclk = cpol;
        #40;
      end
    end
  endtask

  task automatic spi_end();
    #40 spi_cs_n = 1'b1;
    #120;
  endtask

  task automatic run_xfer(input logic cp, input logic ch, input int nw);
    logic [W-1:0] g;
    got_q.delete();
    spi_begin(cp, ch);
    check("busy_after_cs_fall", 32'(busy), 32'd1);
    check("oe_after_cs_fall", 32'(spi_miso_oe), 32'd1);
    if (ch) check("miso_before_first_lead", 32'(spi_miso), 32'd0);
    for (int k = 0; k < nw; k++) begin
      spi_word(send_q[k], W, g);
      got_q.push_back(g);
    end
    spi_end();
    check("busy_after_cs_rise", 32'(busy), 32'd0);
    check("oe_after_cs_rise", 32'(spi_miso_oe), 32'd0);
  endtask

  initial begin
    logic [W-1:0] g;
    logic [W-1:0] tx_model[$];
    int rb;
    int pb;
    int nw;
    int nt;
    logic cp;
    logic ch;

    vecs[0] = '{1'b0, 1'b0, 24'h123456, 24'hA5C3F0, 1'b1, 24'h123456, 24'hA5C3F0, 1};
    vecs[1] = '{1'b0, 1'b1, 24'h123456, 24'hA5C3F0, 1'b1, 24'h123456, 24'hA5C3F0, 1};
    vecs[2] = '{1'b1, 1'b0, 24'h123456, 24'hA5C3F0, 1'b1, 24'h123456, 24'hA5C3F0, 1};
    vecs[3] = '{1'b1, 1'b1, 24'h123456, 24'hA5C3F0, 1'b1, 24'h123456, 24'hA5C3F0, 1};
    vecs[4] = '{1'b0, 1'b0, 24'h000000, 24'h0FFFFF, 1'b0, 24'h000000, 24'h000000, 0};
    vecs[5] = '{1'b1, 1'b1, 24'hFFFFFF, 24'h800001, 1'b1, 24'hFFFFFF, 24'h800001, 1};

    aresetn  = 1'b0;
    cpol     = 1'b0;
    cpha     = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    rx_ready = 1'b1;
    #22;
    check("reset_outputs", 32'({spi_miso, spi_miso_oe, tx_ready, rx_valid, overrun, busy}), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    @(negedge aclk) aresetn = 1'b1;
    #50;

    // Table: single-word transfers across all modes and boundary patterns.
    for (int v = 0; v < 6; v++) begin
      flush_tx();
      if (vecs[v].txv) txq.push_back(vecs[v].tx);
      tx_lim = txq.size();
      send_q = '{vecs[v].mosi};
      rb = rxq.size();
      pb = tx_pulses;
      #20;
      run_xfer(vecs[v].cp, vecs[v].ch, 1);
      check("vec_rx_count", 32'(rxq.size() - rb), 32'd1);
      if (rxq.size() > rb) check("vec_rx_data", 32'(rxq[rb]), 32'(vecs[v].exp_rx));
      check("vec_miso_word", 32'(got_q[0]), 32'(vecs[v].exp_miso));
      check("vec_tx_ready_pulses", 32'(tx_pulses - pb), 32'(vecs[v].exp_rdy));
    end
    check("no_overrun_yet", 32'(overrun), 32'd0);

    // Back-to-back words with nothing to transmit.
    flush_tx();
    send_q = '{24'h000001, 24'hFFFFFE};
    rb = rxq.size();
    pb = tx_pulses;
    run_xfer(1'b0, 1'b0, 2);
    check("b2b_rx_count", 32'(rxq.size() - rb), 32'd2);
    if (rxq.size() >= rb + 2) begin
      check("b2b_rx_word0", 32'(rxq[rb]), 32'h000001);
      check("b2b_rx_word1", 32'(rxq[rb+1]), 32'hFFFFFE);
    end
    check("b2b_miso_word0", 32'(got_q[0]), 32'd0);
    check("b2b_miso_word1", 32'(got_q[1]), 32'd0);
    check("b2b_tx_ready_pulses", 32'(tx_pulses - pb), 32'd0);

    // Random transfers against the word-level model.
    for (int r = 0; r < 20; r++) begin
      cp = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      nw = int'($urandom_range(1, 3));
      nt = int'($urandom_range(0, 3));
      flush_tx();
      tx_model.delete();
      for (int k = 0; k < nt; k++) begin
        g = W'($urandom);
        txq.push_back(g);
        tx_model.push_back(g);
      end
      tx_lim = txq.size();
      send_q.delete();
      for (int k = 0; k < nw; k++) send_q.push_back(W'($urandom));
      rb = rxq.size();
      pb = tx_pulses;
      #20;
      run_xfer(cp, ch, nw);
      check("rand_rx_count", 32'(rxq.size() - rb), 32'(nw));
      for (int k = 0; k < nw; k++) begin
        if (rxq.size() > rb + k) check("rand_rx_data", 32'(rxq[rb+k]), 32'(send_q[k]));
        check("rand_miso_word", 32'(got_q[k]), (k < nt) ? 32'(tx_model[k]) : 32'd0);
      end
      check("rand_tx_ready_pulses", 32'(tx_pulses - pb), 32'((nw + 1 < nt) ? nw + 1 : nt));
    end
    flush_tx();

    // Overrun: two words complete while the sink is stalled.
    @(negedge aclk) rx_ready = 1'b0;
    send_q = '{24'h111111, 24'h222222};
    run_xfer(1'b0, 1'b0, 2);
    check("ovr_rx_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_rx_data_latest", 32'(rx_data), 32'h222222);
    check("ovr_flag_set", 32'(overrun), 32'd1);
    @(negedge aclk);
    #2 rx_ready = 1'b1;
    @(posedge aclk);
    #1;
    check("ovr_rx_valid_cleared", 32'(rx_valid), 32'd0);
    check("ovr_flag_sticky", 32'(overrun), 32'd1);

    // SCLK activity with CS inactive must not start anything.
    @(negedge aclk);
    repeat (3) begin
      #40 spi_sclk = 1'b1;
      #40 spi_sclk = 1'b0;
    end
    #60;
    check("glitch_sclk_idle_busy", 32'(busy), 32'd0);

    // Partial word aborted by CS rise, then a clean word.
    rb = rxq.size();
    spi_begin(1'b0, 1'b0);
    spi_word(24'hFFFFFF, 10, g);
    #40 spi_cs_n = 1'b1;
    repeat (SYNC + 2) @(posedge aclk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_oe", 32'(spi_miso_oe), 32'd0);
    check("abort_miso", 32'(spi_miso), 32'd0);
    #100;
    check("abort_no_rx", 32'(rxq.size() - rb), 32'd0);
    send_q = '{24'hABCDEF};
    run_xfer(1'b0, 1'b0, 1);
    check("abort_next_rx_count", 32'(rxq.size() - rb), 32'd1);
    if (rxq.size() > rb) check("abort_next_rx_data", 32'(rxq[rb]), 32'hABCDEF);

    // Asynchronous reset in the middle of a mode-3 word.
    spi_begin(1'b1, 1'b1);
    spi_word(24'hC3C3C3, 12, g);
    check("midxfer_busy", 32'(busy), 32'd1);
    aresetn = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({spi_miso, spi_miso_oe, tx_ready, rx_valid, overrun, busy}), 32'd0);
    check("rst_mid_rx_data", 32'(rx_data), 32'd0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b1;
    #50;
    @(negedge aclk) aresetn = 1'b1;
    #50;
    rb = rxq.size();
    send_q = '{24'h5A5A5A};
    run_xfer(1'b1, 1'b1, 1);
    check("post_rst_rx_count", 32'(rxq.size() - rb), 32'd1);
    if (rxq.size() > rb) check("post_rst_rx_data", 32'(rxq[rb]), 32'h5A5A5A);
    check("post_rst_overrun", 32'(overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
